// File: rtl/ace_snoop_pkg.sv
// Shared types, ACSNOOP/CRRESP encodings and the snoop response rule table
// for the ACE snoop responder.
package ace_snoop_pkg;

  typedef enum logic [2:0] {
    LS_I  = 3'd0,
    LS_UC = 3'd1,
    LS_UD = 3'd2,
    LS_SC = 3'd3,
    LS_SD = 3'd4
  } line_state_e;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  localparam int unsigned CRRESP_W = 5;
  localparam int unsigned RESP_WU  = 4;
  localparam int unsigned RESP_IS  = 3;
  localparam int unsigned RESP_PD  = 2;
  localparam int unsigned RESP_ERR = 1;
  localparam int unsigned RESP_DT  = 0;

  typedef struct packed {
    logic [CRRESP_W-1:0] crresp;
    line_state_e         next_state;
  } snoop_resp_t;

  // Encodings 5-7 are not legal line states and behave as Invalid.
  function automatic line_state_e to_line_state(input logic [2:0] raw);
    return (raw > 3'd4) ? LS_I : line_state_e'(raw);
  endfunction

  function automatic logic snoop_known(input logic [3:0] snoop);
    logic known;
    case (snoop)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID,
      SNP_MAKE_INVALID: known = 1'b1;
      default:          known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic snoop_resp_t snoop_resp(input logic [3:0] snoop,
                                             input line_state_e state,
                                             input logic hit);
    snoop_resp_t r;
    logic        uniq;
    logic        dirty;
    uniq         = (state == LS_UC) || (state == LS_UD);
    dirty        = (state == LS_UD) || (state == LS_SD);
    r.crresp     = '0;
    r.next_state = state;
    if (!snoop_known(snoop)) begin
      r.crresp[RESP_ERR] = 1'b1;
    end else if (hit) begin
      r.crresp[RESP_WU] = uniq;
      case (snoop)
        SNP_READ_ONCE: begin
          r.crresp[RESP_DT] = 1'b1;
          r.crresp[RESP_IS] = 1'b1;
        end
        SNP_READ_SHARED, SNP_READ_NSD: begin
          r.crresp[RESP_DT] = 1'b1;
          r.crresp[RESP_IS] = 1'b1;
          r.crresp[RESP_PD] = dirty;
          r.next_state      = LS_SC;
        end
        SNP_READ_CLEAN: begin
          r.crresp[RESP_DT] = 1'b1;
          r.crresp[RESP_IS] = 1'b1;
          r.next_state      = dirty ? LS_SD : LS_SC;
        end
        SNP_READ_UNIQUE, SNP_CLEAN_INVALID: begin
          r.crresp[RESP_DT] = (snoop == SNP_READ_UNIQUE) || dirty;
          r.crresp[RESP_PD] = dirty;
          r.next_state      = LS_I;
        end
        SNP_CLEAN_SHARED: begin
          r.crresp[RESP_DT] = dirty;
          r.crresp[RESP_PD] = dirty;
          r.crresp[RESP_IS] = 1'b1;
          if (state == LS_UD)      r.next_state = LS_UC;
          else if (state == LS_SD) r.next_state = LS_SC;
        end
        SNP_MAKE_INVALID: r.next_state = LS_I;
        default: ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ace_snoop_fifo.sv
// Synchronous FIFO buffering accepted AC requests; power-of-2 depth.
module ace_snoop_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: buffers AC snoops, looks up a direct-mapped line-state
// table, answers on CR in order and streams a synthetic line on CD.
module ace_snoop_responder
  import ace_snoop_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned SNOOP_DATA_WIDTH = 128,
  parameter int unsigned CACHE_LINE_SIZE  = 6,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned NUM_LINES        = 16,
  localparam int unsigned IDX_W = $clog2(NUM_LINES),
  localparam int unsigned TAG_W = ADDR_WIDTH - CACHE_LINE_SIZE - IDX_W
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        ACVALID,
  output logic                        ACREADY,
  input  logic [ADDR_WIDTH-1:0]       ACADDR,
  input  logic [3:0]                  ACSNOOP,
  input  logic [2:0]                  ACPROT,
  output logic                        CRVALID,
  input  logic                        CRREADY,
  output logic [4:0]                  CRRESP,
  output logic                        CDVALID,
  input  logic                        CDREADY,
  output logic [SNOOP_DATA_WIDTH-1:0] CDDATA,
  output logic                        CDLAST,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [TAG_W-1:0]            cfg_tag,
  input  logic [2:0]                  cfg_state,
  output logic [15:0]                 hit_count
);

  localparam int unsigned NBEATS     = ((1 << CACHE_LINE_SIZE) * 8) / SNOOP_DATA_WIDTH;
  localparam int unsigned BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned BEAT_BYTES = SNOOP_DATA_WIDTH / 8;
  localparam int unsigned REPL       = SNOOP_DATA_WIDTH / 32;
  localparam int unsigned FIFO_W     = ADDR_WIDTH + 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [31:0] LINE_MASK = 32'((64'd1 << CACHE_LINE_SIZE) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2,
    ST_DATA   = 2'd3
  } fsm_e;

  fsm_e                  fsm;
  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_snoop;
  logic [IDX_W-1:0]      cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic [TAG_W-1:0]      tag_q [NUM_LINES];
  logic [2:0]            st_q  [NUM_LINES];
  line_state_e           lk_state;
  logic                  lk_hit;
  snoop_resp_t           lk_resp;
  logic                  hit_q;
  line_state_e           next_st_q;
  logic                  tbl_upd;
  logic [BEAT_W-1:0]     beat_q;
  logic [BEAT_W-1:0]     beat_nx;
  logic [31:0]           line_base;
  logic                  unused_prot;

  assign unused_prot = ^ACPROT;
  assign ACREADY     = ARESETn && !fifo_full;
  assign fifo_pop    = (fsm == ST_IDLE) && !fifo_empty;

  ace_snoop_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (ACVALID && ACREADY),
    .pop   (fifo_pop),
    .din   ({ACADDR, ACSNOOP}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cur_idx   = cur_addr[CACHE_LINE_SIZE +: IDX_W];
  assign cur_tag   = cur_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lk_state  = to_line_state(st_q[cur_idx]);
  assign lk_hit    = (tag_q[cur_idx] == cur_tag) && (lk_state != LS_I);
  assign lk_resp   = snoop_resp(cur_snoop, lk_state, lk_hit);
  assign line_base = 32'(cur_addr) & ~LINE_MASK;
  assign beat_nx   = beat_q + BEAT_W'(1);
  assign tbl_upd   = (fsm == ST_RESP) && CRREADY && hit_q;

  function automatic logic [SNOOP_DATA_WIDTH-1:0] beat_data(input logic [BEAT_W-1:0] k);
    logic [31:0] w;
    w = line_base + 32'(k) * 32'(BEAT_BYTES);
    return {REPL{w}};
  endfunction

  // Line-state table; a cfg write lands after the response update so it wins.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tag_q <= '{default: '0};
      st_q  <= '{default: '0};
    end else begin
      if (tbl_upd) st_q[cur_idx] <= next_st_q;
      if (cfg_we) begin
        tag_q[cfg_idx] <= cfg_tag;
        st_q[cfg_idx]  <= cfg_state;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      fsm       <= ST_IDLE;
      cur_addr  <= '0;
      cur_snoop <= '0;
      hit_q     <= 1'b0;
      next_st_q <= LS_I;
      beat_q    <= '0;
      CRVALID   <= 1'b0;
      CRRESP    <= '0;
      CDVALID   <= 1'b0;
      CDDATA    <= '0;
      CDLAST    <= 1'b0;
      hit_count <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_addr  <= fifo_dout[FIFO_W-1:4];
            cur_snoop <= fifo_dout[3:0];
            fsm       <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          // Unknown snoops never count as hits and never touch the table.
          hit_q     <= lk_hit && snoop_known(cur_snoop);
          next_st_q <= lk_resp.next_state;
          CRRESP    <= lk_resp.crresp;
          CRVALID   <= 1'b1;
          fsm       <= ST_RESP;
        end
        ST_RESP: begin
          if (CRREADY) begin
            CRVALID <= 1'b0;
            CRRESP  <= '0;
            if (hit_q && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
            if (CRRESP[RESP_DT]) begin
              beat_q  <= '0;
              CDVALID <= 1'b1;
              CDDATA  <= beat_data('0);
              CDLAST  <= (LAST_BEAT == '0);
              fsm     <= ST_DATA;
            end else begin
              fsm <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (CDREADY) begin
            if (CDLAST) begin
              CDVALID <= 1'b0;
              CDDATA  <= '0;
              CDLAST  <= 1'b0;
              fsm     <= ST_IDLE;
            end else begin
              beat_q <= beat_nx;
              CDDATA <= beat_data(beat_nx);
              CDLAST <= (beat_nx == LAST_BEAT);
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder with a CR/CD expectation scoreboard.
module tb_ace_snoop_responder;
  import ace_snoop_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = 54;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          ACVALID;
  logic          ACREADY;
  logic [AW-1:0] ACADDR;
  logic [3:0]    ACSNOOP;
  logic [2:0]    ACPROT;
  logic          CRVALID;
  logic          CRREADY;
  logic [4:0]    CRRESP;
  logic          CDVALID;
  logic          CDREADY;
  logic [DW-1:0] CDDATA;
  logic          CDLAST;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [TW-1:0] cfg_tag;
  logic [2:0]    cfg_state;
  logic [15:0]   hit_count;

  int total = 0;
  int bad   = 0;
  logic [4:0]  exp_cr [$];
  logic [DW:0] exp_cd [$];

  always #5 ACLK = ~ACLK;

  ace_snoop_responder dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ACVALID   (ACVALID),
    .ACREADY   (ACREADY),
    .ACADDR    (ACADDR),
    .ACSNOOP   (ACSNOOP),
    .ACPROT    (ACPROT),
    .CRVALID   (CRVALID),
    .CRREADY   (CRREADY),
    .CRRESP    (CRRESP),
    .CDVALID   (CDVALID),
    .CDREADY   (CDREADY),
    .CDDATA    (CDDATA),
    .CDLAST    (CDLAST),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_tag   (cfg_tag),
    .cfg_state (cfg_state),
    .hit_count (hit_count)
  );

  task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expectations on every CR/CD handshake.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && CRVALID && CRREADY) begin
      total++;
      assert (exp_cr.size() > 0) else begin
        bad++;
        $error("FAIL cr_extra got=%0h exp=none", CRRESP);
      end
      if (exp_cr.size() > 0) chk("crresp", (DW+1)'(CRRESP), (DW+1)'(exp_cr.pop_front()));
    end
    if (ARESETn === 1'b1 && CDVALID && CDREADY) begin
      total++;
      assert (exp_cd.size() > 0) else begin
        bad++;
        $error("FAIL cd_extra got=%0h exp=none", CDDATA);
      end
      if (exp_cd.size() > 0) chk("cd_beat", {CDLAST, CDDATA}, exp_cd.pop_front());
    end
  end

  task automatic cfg(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [2:0] st);
    cfg_we = 1'b1; cfg_idx = idx; cfg_tag = tag; cfg_state = st;
    @(posedge ACLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [3:0] s,
                      input logic [4:0] cr, input bit dt);
    int n;
    logic [31:0] w;
    exp_cr.push_back(cr);
    if (dt) begin
      for (int k = 0; k < 4; k++) begin
        w = (a[31:0] & 32'hFFFF_FFC0) + 32'(k * 16);
        exp_cd.push_back({k == 3, {4{w}}});
      end
    end
    ACADDR = a; ACSNOOP = s; ACVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ACREADY && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    chk("ac_accept", (DW+1)'(ACREADY), (DW+1)'(1'b1));
    @(posedge ACLK); #1;
    ACVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_cr.size() != 0 || exp_cd.size() != 0) && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    chk("drain", (DW+1)'(exp_cr.size() + exp_cd.size()), '0);
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_cdvalid();
    int n;
    n = 0;
    @(negedge ACLK);
    while (!CDVALID && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk("cdvalid_seen", (DW+1)'(CDVALID), (DW+1)'(1'b1));
  endtask

  initial begin
    ARESETn = 1'b0; ACVALID = 1'b0; ACADDR = '0; ACSNOOP = '0; ACPROT = 3'b010;
    CRREADY = 1'b1; CDREADY = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_tag = '0; cfg_state = '0;

    // Reset state
    #12;
    chk("rst_acready", (DW+1)'(ACREADY), '0);
    chk("rst_crvalid", (DW+1)'(CRVALID), '0);
    chk("rst_crresp", (DW+1)'(CRRESP), '0);
    chk("rst_cd", {CDLAST, CDDATA}, '0);
    chk("rst_cdvalid", (DW+1)'(CDVALID), '0);
    chk("rst_hits", (DW+1)'(hit_count), '0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    #1;
    chk("acready_out_of_reset", (DW+1)'(ACREADY), (DW+1)'(1'b1));

    // ReadShared on UD, then again on the resulting SC line
    cfg(4'd3, '0, 3'(LS_UD));
    send(64'hC0, SNP_READ_SHARED, 5'b11101, 1);
    wait_idle();
    chk("hits_after_rs", (DW+1)'(hit_count), (DW+1)'(16'd1));
    send(64'hC0, SNP_READ_SHARED, 5'b01001, 1);
    wait_idle();

    // ReadUnique miss
    send(64'h1000, SNP_READ_UNIQUE, 5'b00000, 0);
    wait_idle();
    chk("hits_after_miss", (DW+1)'(hit_count), (DW+1)'(16'd2));

    // CleanInvalid on SC invalidates; following ReadOnce misses
    cfg(4'd5, '0, 3'(LS_SC));
    send(64'h140, SNP_CLEAN_INVALID, 5'b00000, 0);
    send(64'h140, SNP_READ_ONCE, 5'b00000, 0);
    wait_idle();
    chk("hits_after_ci", (DW+1)'(hit_count), (DW+1)'(16'd3));

    // CR backpressure fills the FIFO; responses must return in order
    cfg(4'd1, '0, 3'(LS_UC));
    cfg(4'd2, '0, 3'(LS_SD));
    cfg(4'd4, '0, 3'(LS_UD));
    CRREADY = 1'b0;
    send(64'h40,  SNP_CLEAN_SHARED, 5'b11000, 0);
    send(64'h80,  SNP_MAKE_INVALID, 5'b00000, 0);
    send(64'h0,   4'b0101,          5'b00010, 0);
    send(64'h100, SNP_CLEAN_SHARED, 5'b11101, 1);
    send(64'h80,  SNP_READ_ONCE,    5'b00000, 0);
    chk("acready_full", (DW+1)'(ACREADY), '0);
    fork
      send(64'h40, SNP_MAKE_INVALID, 5'b10000, 0);
      begin
        repeat (5) @(posedge ACLK);
        #1;
        chk("acready_still_full", (DW+1)'(ACREADY), '0);
        CRREADY = 1'b1;
      end
    join
    wait_idle();
    chk("hits_after_bp", (DW+1)'(hit_count), (DW+1)'(16'd7));

    // Unknown snoop type answers Error
    send(64'h200, 4'b0101, 5'b00010, 0);
    wait_idle();

    // CD stalls: beat 0 and beat 1 must hold while CDREADY is low
    CDREADY = 1'b0;
    send(64'h100, SNP_READ_ONCE, 5'b11001, 1);
    wait_cdvalid();
    repeat (10) begin
      @(negedge ACLK);
      chk("cd_hold_beat0", {CDLAST, CDDATA}, {1'b0, {4{32'h100}}});
    end
    @(posedge ACLK); #1; CDREADY = 1'b1;
    @(posedge ACLK); #1; CDREADY = 1'b0;
    repeat (10) begin
      @(negedge ACLK);
      chk("cd_hold_beat1", {CDLAST, CDDATA}, {1'b0, {4{32'h110}}});
    end
    CDREADY = 1'b1;
    wait_idle();
    chk("hits_after_stall", (DW+1)'(hit_count), (DW+1)'(16'd8));

    // Reset in the middle of a burst abandons it and clears the table
    cfg(4'd7, '0, 3'(LS_UD));
    CDREADY = 1'b0;
    send(64'h1C0, SNP_READ_SHARED, 5'b11101, 1);
    wait_cdvalid();
    @(posedge ACLK); #1; CDREADY = 1'b1;
    @(posedge ACLK); #1; CDREADY = 1'b0;
    #1 ARESETn = 1'b0;
    #1;
    exp_cd.delete();
    exp_cr.delete();
    chk("midrst_cd", {CDLAST, CDDATA}, '0);
    chk("midrst_cdvalid", (DW+1)'(CDVALID), '0);
    chk("midrst_cr", (DW+1)'({CRVALID, CRRESP}), '0);
    chk("midrst_acready", (DW+1)'(ACREADY), '0);
    chk("midrst_hits", (DW+1)'(hit_count), '0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    CDREADY = 1'b1;
    send(64'h1C0, SNP_READ_SHARED, 5'b00000, 0);
    send(64'hC0,  SNP_READ_SHARED, 5'b00000, 0);
    wait_idle();
    chk("hits_after_reset", (DW+1)'(hit_count), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
